// File: rtl/crossing_request_arbiter.sv
// Round-robin scheduler for crossing requests: edge-captured pending bits, valid/ack grant, minimum quiet gap.
// Optional offer timeout is enabled by defining ARB_TIMEOUT_EN.
module crossing_request_arbiter #(
  parameter int unsigned MIN_GAP = 1000,
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_clean,
  input  logic       grant_ack,
  input  logic       service_done,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic [3:0] pending,
  output logic       timeout
);

  if (MIN_GAP < 1 || MIN_GAP >= (1 << 19) || TIMEOUT < 1 || TIMEOUT >= (1 << 19)) begin : g_bad_param
    $error("crossing_request_arbiter: MIN_GAP and TIMEOUT must be in [1, 2^19)");
  end

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    SERVE,
    GAP
  } state_t;

  localparam logic [18:0] GAP_LAST = 19'(MIN_GAP - 1);
`ifdef ARB_TIMEOUT_EN
  localparam logic [18:0] TO_LAST  = 19'(TIMEOUT - 1);
`endif

  state_t      state;
  logic [3:0]  req_prev;
  logic [3:0]  rise_q;
  logic [1:0]  rr_ptr;
  logic [18:0] cnt;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic [3:0]  clr_mask;

  // Descending scan so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    pick = rr_ptr;
    idx  = rr_ptr;
    for (int unsigned k = 4; k > 0; k--) begin
      idx = rr_ptr + 2'(k - 1);
      if (pending[idx]) pick = idx;
    end
  end

  always_comb begin
    clr_mask = '0;
    if (state == OFFER && grant_ack) clr_mask = 4'b0001 << grant_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      cnt         <= '0;
      req_prev    <= req_clean;
      rise_q      <= '0;
    end else begin
      req_prev <= req_clean;
      rise_q   <= req_clean & ~req_prev;
      timeout  <= 1'b0;
      // A fresh edge for the id being acked re-arms it: set wins over clear.
      pending  <= (pending & ~clr_mask) | rise_q;
      case (state)
        IDLE: begin
          if (|pending) begin
            grant_id    <= pick;
            grant_valid <= 1'b1;
            cnt         <= '0;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ack) begin
            grant_valid <= 1'b0;
            rr_ptr      <= grant_id + 2'd1;
            state       <= SERVE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            rr_ptr      <= grant_id + 2'd1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 19'd1;
          end
`endif
        end
        SERVE: begin
          if (service_done) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) state <= IDLE;
          else                 cnt   <= cnt + 19'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crossing_request_arbiter.sv
// Bench for crossing_request_arbiter: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model. Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_crossing_request_arbiter;

  localparam int unsigned MIN_GAP = 5;
  localparam int unsigned TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_clean = 4'b0010;
  logic       grant_ack = 1'b0;
  logic       service_done = 1'b0;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] pending;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  crossing_request_arbiter #(.MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .req_clean(req_clean),
    .grant_ack(grant_ack),
    .service_done(service_done),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .pending(pending),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: requests as a list of flags, phases as flags/countdowns.
  bit m_pend[4];
  bit m_prev[4];
  bit m_rise[4];
  bit rise_now[4];
  int m_rr, m_id, m_age, m_quiet, clr;
  bit m_offering, m_serving, m_to, picked;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) rise_now[i] = req_clean[i] && !m_prev[i];
    m_to = 1'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 1'b0;
        m_rise[i] = 1'b0;
      end
      m_rr = 0; m_id = 0; m_age = 0; m_quiet = 0;
      m_offering = 1'b0; m_serving = 1'b0;
    end else begin
      clr = -1;
      if (m_offering) begin
        if (grant_ack) begin
          clr = m_id;
          m_rr = (m_id + 1) % 4;
          m_offering = 1'b0;
          m_serving = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          m_age++;
          if (m_age == TIMEOUT) begin
            m_offering = 1'b0;
            m_to = 1'b1;
            m_rr = (m_id + 1) % 4;
            m_quiet = MIN_GAP;
          end
        end
`endif
      end else if (m_serving) begin
        if (service_done) begin
          m_serving = 1'b0;
          m_quiet = MIN_GAP;
        end
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else begin
        picked = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!picked && m_pend[(m_rr + k) % 4]) begin
            picked = 1'b1;
            m_id = (m_rr + k) % 4;
          end
        end
        if (picked) begin
          m_offering = 1'b1;
          m_age = 0;
        end
      end
      if (clr >= 0) m_pend[clr] = 1'b0;
      for (int i = 0; i < 4; i++) if (m_rise[i]) m_pend[i] = 1'b1;
      m_rise = rise_now;
    end
    for (int i = 0; i < 4; i++) m_prev[i] = req_clean[i];
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_grant_valid", {3'b0, grant_valid}, {3'b0, m_offering});
      check("model_grant_id", {2'b0, grant_id}, 4'(m_id));
      check("model_pending", pending, {m_pend[3], m_pend[2], m_pend[1], m_pend[0]});
      check("model_timeout", {3'b0, timeout}, {3'b0, m_to});
    end
  end

  task automatic wait_grant(input int bound);
    int n = 0;
    while (grant_valid !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("grant_within_bound", {3'b0, grant_valid}, 4'h1);
  endtask

  task automatic serve_one(input logic [3:0] exp_id);
    wait_grant(40);
    check("grant_seq_id", {2'b0, grant_id}, exp_id);
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    @(negedge clk);
    service_done = 1'b1;
    @(negedge clk);
    service_done = 1'b0;
  endtask

  task automatic do_reset();
    grant_ack = 1'b0;
    service_done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, to_cnt;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Input high through reset creates no request.
    repeat (4) @(negedge clk);
    check("held_at_reset_pending", pending, 4'b0000);
    check("held_at_reset_valid", {3'b0, grant_valid}, 4'h0);

    // Latency and gap boundary.
    req_clean = 4'b0000;
    repeat (2) @(negedge clk);
    req_clean = 4'b0100;
    @(negedge clk);
    check("lat_pend_edge_n", pending, 4'b0000);
    @(negedge clk);
    check("lat_pend_n1", pending, 4'b0100);
    check("lat_valid_n1", {3'b0, grant_valid}, 4'h0);
    @(negedge clk);
    check("lat_valid_n2", {3'b0, grant_valid}, 4'h1);
    check("lat_id_n2", {2'b0, grant_id}, 4'h2);
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    check("ack_valid_low", {3'b0, grant_valid}, 4'h0);
    check("ack_pend_clear", pending, 4'b0000);
    req_clean = 4'b0110;
    repeat (3) @(negedge clk);
    service_done = 1'b1;
    @(negedge clk);
    service_done = 1'b0;
    for (int k = 1; k <= int'(MIN_GAP); k++) begin
      @(negedge clk);
      check("gap_no_grant", {3'b0, grant_valid}, 4'h0);
    end
    @(negedge clk);
    check("gap_first_grant", {3'b0, grant_valid}, 4'h1);
    check("gap_first_id", {2'b0, grant_id}, 4'h1);
    serve_one(4'h1);

    // Simultaneous requests in round-robin order from rr_ptr=0.
    req_clean = 4'b0000;
    do_reset();
    req_clean = 4'b1011;
    serve_one(4'h0);
    serve_one(4'h1);
    serve_one(4'h3);
    req_clean = 4'b0000;

    // Re-press during service goes behind other pending requesters.
    do_reset();
    req_clean = 4'b0110;
    wait_grant(10);
    check("repress_first_id", {2'b0, grant_id}, 4'h1);
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    req_clean = 4'b0100;
    @(negedge clk);
    req_clean = 4'b0110;
    repeat (3) @(negedge clk);
    check("repress_pending", pending, 4'b0110);
    service_done = 1'b1;
    @(negedge clk);
    service_done = 1'b0;
    serve_one(4'h2);
    serve_one(4'h1);
    req_clean = 4'b0000;

    // Reset during SERVE and during GAP.
    do_reset();
    req_clean = 4'b0001;
    wait_grant(10);
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    req_clean = 4'b1001;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_serve_valid", {3'b0, grant_valid}, 4'h0);
    check("rst_serve_pending", pending, 4'b0000);
    req_clean = 4'b0000;
    @(negedge clk);
    req_clean = 4'b0100;
    wait_grant(10);
    check("rst_serve_fresh_id", {2'b0, grant_id}, 4'h2);
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    service_done = 1'b1;
    @(negedge clk);
    service_done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_gap_valid", {3'b0, grant_valid}, 4'h0);
    check("rst_gap_pending", pending, 4'b0000);
    req_clean = 4'b0110;
    wait_grant(4);
    check("rst_gap_fresh_id", {2'b0, grant_id}, 4'h1);
    serve_one(4'h1);
    req_clean = 4'b0000;

`ifdef ARB_TIMEOUT_EN
    // Unacked offer expires after TIMEOUT cycles and is re-offered after the gap.
    do_reset();
    req_clean = 4'b1000;
    wait_grant(10);
    n = 0;
    while (grant_valid === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("to_valid_cycles", 4'(n), 4'(TIMEOUT));
    check("to_pulse", {3'b0, timeout}, 4'h1);
    check("to_pending_kept", pending, 4'b1000);
    to_cnt = 1;
    n = 0;
    while (grant_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      if (timeout === 1'b1) to_cnt++;
      n++;
    end
    check("to_reoffer_valid", {3'b0, grant_valid}, 4'h1);
    check("to_reoffer_id", {2'b0, grant_id}, 4'h3);
    check("to_single_pulse", 4'(to_cnt), 4'h1);
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    service_done = 1'b1;
    @(negedge clk);
    service_done = 1'b0;
    req_clean = 4'b0000;
`endif

    // Randomized traffic, checked every cycle against the model.
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) req_clean[i] = ~req_clean[i];
      grant_ack    = ($urandom_range(2) == 0);
      service_done = ($urandom_range(4) == 0);
      reset        = ($urandom_range(399) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    grant_ack = 1'b0;
    service_done = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crossing_request_arbiter.md
# crossing_request_arbiter

Scheduler that sits between the per-input debouncers and the traffic-light phase FSM. It turns four debounced request levels (pedestrian buttons and vehicle loop sensors) into latched pending requests. It grants them one at a time in round-robin order over a valid/ack handshake, and enforces a minimum quiet gap between consecutive services. This lets the single light sequencer be shared fairly between all crossing requesters.

## Interface
Parameters:
- MIN_GAP, default 1000: number of clk cycles spent in GAP after each service. Must be ≥1 and < 2^19.
- TIMEOUT, default 5000: maximum number of cycles a grant is offered without ack. Only used when ARB_TIMEOUT_EN is defined. Must be ≥1 and < 2^19.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: reset, synchronous, active-high.
- req_clean, input, 4: debounced request levels, one bit per requester.
- grant_ack, input, 1: the phase FSM accepts the offered grant.
- service_done, input, 1: single-cycle pulse from the phase FSM when the granted phase completes.
- grant_valid, output, 1: a grant is being offered.
- grant_id, output, 2: index of the granted requester. Stable while grant_valid is high and through SERVE.
- pending, output, 4: latched, not-yet-granted requests.
- timeout, output, 1: single-cycle pulse when an offer expires. Tied to 0 without ARB_TIMEOUT_EN.

## Operation
- Edge capture: a `req_prev` register samples `req_clean` every cycle. A rising edge (`req_clean & ~req_prev`) sets the matching `pending` bit.
  - Holding a request high produces only one request.
- States:
  - IDLE: if `pending` is not 0, pick the first set bit searching from `rr_ptr` upward with wrap (3→0). Load `grant_id` and go to OFFER. Otherwise stay in IDLE.
  - OFFER: `grant_valid`=1. If `grant_ack` is high, clear `pending[grant_id]`, set `rr_ptr`=`grant_id`+1 mod 4, and go to SERVE.
  - SERVE: `grant_valid`=0 and `grant_id` held. On `service_done`, clear the gap counter and go to GAP.
  - GAP: the 19-bit counter increments each cycle. When counter == MIN_GAP-1, go to IDLE.
- Simultaneous set and clear of the same `pending` bit (new rising edge in the same cycle as ack for that id): the set wins, so the bit stays 1.
- A requester re-pressing while it is being served becomes a new pending request. It is served only after the other pending requesters, per round-robin.
- Outside SERVE, `service_done` is ignored. Outside OFFER, `grant_ack` is ignored.
- `rr_ptr` changes only on an accepted grant (or on a timeout, with ARB_TIMEOUT_EN).

## Timing
- Reset values: state=IDLE, `pending`=0, `rr_ptr`=0, `grant_valid`=0, `grant_id`=0, `timeout`=0, counter=0.
  - `req_prev` loads `req_clean` on reset, so inputs already high at reset do not create requests.
- All outputs are registered.
- Latency: rising edge sampled at edge N → `pending` bit set after edge N+1 → `grant_valid` high after edge N+2, provided the arbiter was in IDLE.
- Ack: `grant_ack` sampled high at edge M → `grant_valid` low and `pending` bit cleared after edge M.
- `service_done` sampled at edge S → state is GAP for exactly MIN_GAP cycles → IDLE. The next grant can appear at the earliest MIN_GAP+1 cycles after S.
- A reset asserted in any state aborts the operation at the next edge. All pending requests are discarded.

## Configuration
- ARB_TIMEOUT_EN defined: OFFER counts cycles using the gap counter, cleared on entry to OFFER.
  - If TIMEOUT cycles elapse without `grant_ack`: `grant_valid` drops, `timeout` pulses for 1 cycle, `pending[grant_id]` is kept, `rr_ptr`=`grant_id`+1, and the state goes to GAP.
- ARB_TIMEOUT_EN undefined: OFFER waits for `grant_ack` indefinitely. The `timeout` output is constant 0.

## Test plan
- Reset with `req_clean`=4'b0010 held high, then release reset → `pending` stays 0 and no grant is issued.
- Rising edge on `req_clean[2]` while idle → `pending`=4'b0100 one cycle later, then `grant_valid`=1 with `grant_id`=2. Ack → `pending`=0. `service_done` → next grant no earlier than MIN_GAP+1 cycles later.
- `req_clean`=4'b1011 rising simultaneously, `rr_ptr`=0, each grant acked and completed → `grant_id` sequence 0, 1, 3.
- Requester 1 re-presses during its SERVE while requester 2 is pending → next grants are 2, then 1.
- Reset asserted during SERVE and during GAP → next cycle state is IDLE, `pending`=0, `grant_valid`=0. Then a fresh request is granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT=8, no ack → `grant_valid` high for exactly 8 cycles, `timeout` pulses once, the pending bit remains set, and the request is re-offered after the gap.
